// File: rtl/fm7_sub_busctl_if.sv
// Sub-system bus bundle between the display sub-CPU side and fm7_sub_busctl.
interface fm7_sub_busctl_if;
    logic [15:0] SADDRBUS;
    logic        SRW;
    logic        SBA;
    logic        SBS;
    logic        MHALTREQ;
    logic        SE;
    logic        SQ;
    logic        SHALTn;
    logic        SHALTACK;
    logic        SRAM1CSn;
    logic        SRAM2CSn;
    logic        SSHRCSn;
    logic        SIOCSn;
    logic        SROMDn;
    logic        SROMSELn;
    logic        SVRAMCSn;
    logic        SRDQEn;
    logic        SWTQEn;
    logic        SCYCEND;
    logic [1:0]  dbg_halt_state;
    logic [1:0]  dbg_phase;

    // Halt handshake: MHALTREQ is a level request; SHALTn drops at the E fall that
    // sees it, SHALTACK rises only once BA=BS=1 has been seen at a later E fall, and
    // both release together at the E fall after MHALTREQ goes low.
    modport master (
        output SADDRBUS, SRW, SBA, SBS, MHALTREQ,
        input  SE, SQ, SHALTn, SHALTACK,
        input  SRAM1CSn, SRAM2CSn, SSHRCSn, SIOCSn, SROMDn, SROMSELn, SVRAMCSn,
        input  SRDQEn, SWTQEn, SCYCEND, dbg_halt_state, dbg_phase
    );

    modport slave (
        input  SADDRBUS, SRW, SBA, SBS, MHALTREQ,
        output SE, SQ, SHALTn, SHALTACK,
        output SRAM1CSn, SRAM2CSn, SSHRCSn, SIOCSn, SROMDn, SROMSELn, SVRAMCSn,
        output SRDQEn, SWTQEn, SCYCEND, dbg_halt_state, dbg_phase
    );
endinterface

// File: rtl/fm7_sub_busctl.sv
// FM-7 sub-CPU bus controller: E/Q generation, per-cycle address decode into
// registered chip selects/strobes, and the main-CPU halt handshake.
module fm7_sub_busctl #(
    parameter int unsigned PHASE_LEN = 2
) (
    input  logic            CLKSYS,
    input  logic            RST,
    fm7_sub_busctl_if.slave bus
);
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        REQ    = 2'd1,
        HALTED = 2'd2
    } halt_state_t;

    localparam logic [3:0] SUB_LAST = 4'(PHASE_LEN - 1);

    // Select vector order: {vram, romsel, romd, io, shr, ram2, ram1}, active high.
    function automatic logic [6:0] decode(input logic [15:0] a);
        logic [6:0] s;
        s = 7'd0;
        if (a < 16'hC000)      s[6] = 1'b1;
        else if (a < 16'hC800) s[0] = 1'b1;
        else if (a < 16'hD000) s[1] = 1'b1;
        else if (a < 16'hD380) s = 7'd0;
        else if (a < 16'hD400) s[2] = 1'b1;
        else if (a < 16'hD800) s[3] = 1'b1;
        else if (a < 16'hE000) s[4] = 1'b1;
        else                   s[5] = 1'b1;
        return s;
    endfunction

    halt_state_t state_q, state_n;
    logic [3:0]  sub_q, sub_n;
    logic [1:0]  phase_q, phase_n;
    logic [15:0] addr_q, addr_src;
    logic        rw_q, rw_src;
    logic        sub_wrap, sample, cyc_last, window_n;
    logic [6:0]  sel_n;
    logic        rd_n, wr_n, cycend_n;
    logic        se_q, sq_q, shaltn_q, shaltack_q, rdn_q, wrn_q, cycend_q;
    logic [6:0]  csn_q;

    // Everything below looks one clock ahead so every output comes straight off a flop.
    always_comb begin
        sub_wrap = (sub_q == SUB_LAST);
        sub_n    = sub_wrap ? 4'd0 : sub_q + 4'd1;
        phase_n  = sub_wrap ? phase_q + 2'd1 : phase_q;
        sample   = (phase_q == 2'd1) && (sub_q == 4'd0);
        cyc_last = (phase_q == 2'd3) && sub_wrap;
        addr_src = sample ? bus.SADDRBUS : addr_q;
        rw_src   = sample ? bus.SRW : rw_q;
        window_n = ((phase_n == 2'd1) && (sub_n != 4'd0)) || phase_n[1];
        sel_n    = (window_n && (state_q != HALTED)) ? decode(addr_src) : 7'd0;
        rd_n     = (|sel_n) && rw_src && phase_n[1];
        wr_n     = (|sel_n) && !rw_src && (phase_n == 2'd3);
        cycend_n = (phase_n == 2'd3) && (sub_n == SUB_LAST);
    end

    always_comb begin
        state_n = state_q;
        if (cyc_last) begin
            case (state_q)
                RUN:     if (bus.MHALTREQ) state_n = REQ;
                REQ:     if (!bus.MHALTREQ) state_n = RUN;
                         else if (bus.SBA && bus.SBS) state_n = HALTED;
                HALTED:  if (!bus.MHALTREQ) state_n = RUN;
                default: state_n = RUN;
            endcase
        end
    end

    always_ff @(posedge CLKSYS) begin
        if (RST) begin
            sub_q      <= 4'd0;
            phase_q    <= 2'd0;
            state_q    <= RUN;
            addr_q     <= 16'd0;
            rw_q       <= 1'b1;
            se_q       <= 1'b0;
            sq_q       <= 1'b0;
            shaltn_q   <= 1'b1;
            shaltack_q <= 1'b0;
            csn_q      <= 7'h7F;
            rdn_q      <= 1'b1;
            wrn_q      <= 1'b1;
            cycend_q   <= 1'b0;
        end else begin
            sub_q      <= sub_n;
            phase_q    <= phase_n;
            state_q    <= state_n;
            if (sample) begin
                addr_q <= bus.SADDRBUS;
                rw_q   <= bus.SRW;
            end
            se_q       <= phase_n[1];
            sq_q       <= phase_n[1] ^ phase_n[0];
            shaltn_q   <= (state_n == RUN);
            shaltack_q <= (state_n == HALTED);
            csn_q      <= ~sel_n;
            rdn_q      <= ~rd_n;
            wrn_q      <= ~wr_n;
            cycend_q   <= cycend_n;
        end
    end

    assign bus.SE             = se_q;
    assign bus.SQ             = sq_q;
    assign bus.SHALTn         = shaltn_q;
    assign bus.SHALTACK       = shaltack_q;
    assign bus.SRAM1CSn       = csn_q[0];
    assign bus.SRAM2CSn       = csn_q[1];
    assign bus.SSHRCSn        = csn_q[2];
    assign bus.SIOCSn         = csn_q[3];
    assign bus.SROMDn         = csn_q[4];
    assign bus.SROMSELn       = csn_q[5];
    assign bus.SVRAMCSn       = csn_q[6];
    assign bus.SRDQEn         = rdn_q;
    assign bus.SWTQEn         = wrn_q;
    assign bus.SCYCEND        = cycend_q;
    assign bus.dbg_halt_state = state_q;
    assign bus.dbg_phase      = phase_q;
endmodule

// File: tb/tb_fm7_sub_busctl.sv
// Directed bench for fm7_sub_busctl (PHASE_LEN=2): each bus cycle's expected
// chip-select/strobe/halt picture is queued and checked at SCYCEND.
module tb_fm7_sub_busctl;
    localparam int W = 11;
    localparam logic [6:0] CS_RAM1   = 7'b1111110;
    localparam logic [6:0] CS_RAM2   = 7'b1111101;
    localparam logic [6:0] CS_SHR    = 7'b1111011;
    localparam logic [6:0] CS_IO     = 7'b1110111;
    localparam logic [6:0] CS_ROMD   = 7'b1101111;
    localparam logic [6:0] CS_ROMSEL = 7'b1011111;
    localparam logic [6:0] CS_VRAM   = 7'b0111111;
    localparam logic [6:0] CS_NONE   = 7'b1111111;
    // {SE,SQ,SHALTn,SHALTACK,cs[6:0],SRDQEn,SWTQEn,SCYCEND,state,phase}
    localparam logic [17:0] RESET_VIEW = {2'b00, 1'b1, 1'b0, 7'h7F, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0};

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;
    logic [W-1:0] exp_q[$];
    logic [111:0] trace = '0;

    fm7_sub_busctl_if bus();
    fm7_sub_busctl #(.PHASE_LEN(2)) dut (.CLKSYS(clk), .RST(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [111:0] build_trace(input logic [W-1:0] x);
        logic [111:0] t;
        logic [13:0]  s;
        logic         haltn, ack, rd, wr;
        logic [6:0]   cs;
        {haltn, ack, rd, wr, cs} = x;
        t = '0;
        for (int c = 0; c < 8; c++) begin
            s = {(c >= 4), (c >= 2 && c <= 5), haltn, ack,
                 (c >= 3) ? cs : CS_NONE, !(rd && c >= 4), !(wr && c >= 6), (c == 7)};
            t = {t[97:0], s};
        end
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [17:0] reset_view();
        return {bus.SE, bus.SQ, bus.SHALTn, bus.SHALTACK, bus.SVRAMCSn, bus.SROMSELn,
                bus.SROMDn, bus.SIOCSn, bus.SSHRCSn, bus.SRAM2CSn, bus.SRAM1CSn,
                bus.SRDQEn, bus.SWTQEn, bus.SCYCEND, bus.dbg_halt_state, bus.dbg_phase};
    endfunction

    // Monitor: keeps the last eight clocks of outputs and compares them whenever a cycle ends.
    always @(negedge clk) begin
        logic [13:0]  s;
        logic [111:0] e;
        logic [W-1:0] x;
        s = {bus.SE, bus.SQ, bus.SHALTn, bus.SHALTACK, bus.SVRAMCSn, bus.SROMSELn, bus.SROMDn,
             bus.SIOCSn, bus.SSHRCSn, bus.SRAM2CSn, bus.SRAM1CSn, bus.SRDQEn, bus.SWTQEn, bus.SCYCEND};
        trace = {trace[97:0], s};
        if (bus.SCYCEND === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL cycle_end: cycle ended with nothing expected, trace %h", trace);
            end else begin
                x = exp_q.pop_front();
                e = build_trace(x);
                if (trace !== e) begin
                    miscompares++;
                    $display("FAIL cycle %0d: got trace %h expected %h", vectors, trace, e);
                end
            end
        end
    end

    task automatic run_cycle(input logic [15:0] addr, input logic rw, input logic hreq,
                             input logic ba_bs, input logic [6:0] cs, input logic rd,
                             input logic wr, input logic haltn, input logic ack);
        bus.SADDRBUS = addr;
        bus.SRW      = rw;
        bus.MHALTREQ = hreq;
        bus.SBA      = ba_bs;
        bus.SBS      = ba_bs;
        exp_q.push_back({haltn, ack, rd, wr, cs});
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic run_cycle_glitch(input logic [15:0] addr, input logic rw,
                                    input logic [15:0] alt_addr, input logic alt_rw,
                                    input logic [6:0] cs, input logic rd, input logic wr);
        bus.SADDRBUS = addr;
        bus.SRW      = rw;
        exp_q.push_back({1'b1, 1'b0, rd, wr, cs});
        repeat (4) @(posedge clk);
        #1;
        bus.SADDRBUS = alt_addr;
        bus.SRW      = alt_rw;
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        bus.SADDRBUS = 16'hD000;
        bus.SRW      = 1'b1;
        bus.SBA      = 1'b0;
        bus.SBS      = 1'b0;
        bus.MHALTREQ = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_values", 32'(reset_view()), 32'(RESET_VIEW));
        rst = 1'b0;

        // free-run on the unmapped hole, then basic read/write
        run_cycle(16'hD000, 1'b1, 1'b0, 1'b0, CS_NONE, 1'b0, 1'b0, 1'b1, 1'b0);
        run_cycle(16'hD000, 1'b0, 1'b0, 1'b0, CS_NONE, 1'b0, 1'b0, 1'b1, 1'b0);
        run_cycle(16'hE123, 1'b1, 1'b0, 1'b0, CS_ROMSEL, 1'b1, 1'b0, 1'b1, 1'b0);
        run_cycle(16'hC800, 1'b0, 1'b0, 1'b0, CS_RAM2, 1'b0, 1'b1, 1'b1, 1'b0);
        run_cycle(16'hC7FF, 1'b0, 1'b0, 1'b0, CS_RAM1, 1'b0, 1'b1, 1'b1, 1'b0);

        // decode boundaries
        run_cycle(16'hBFFF, 1'b1, 1'b0, 1'b0, CS_VRAM, 1'b1, 1'b0, 1'b1, 1'b0);
        run_cycle(16'hC000, 1'b1, 1'b0, 1'b0, CS_RAM1, 1'b1, 1'b0, 1'b1, 1'b0);
        run_cycle(16'hD37F, 1'b1, 1'b0, 1'b0, CS_NONE, 1'b0, 1'b0, 1'b1, 1'b0);
        run_cycle(16'hD380, 1'b1, 1'b0, 1'b0, CS_SHR, 1'b1, 1'b0, 1'b1, 1'b0);
        run_cycle(16'hD3FF, 1'b1, 1'b0, 1'b0, CS_SHR, 1'b1, 1'b0, 1'b1, 1'b0);
        run_cycle(16'hD400, 1'b1, 1'b0, 1'b0, CS_IO, 1'b1, 1'b0, 1'b1, 1'b0);
        run_cycle(16'hD7FF, 1'b1, 1'b0, 1'b0, CS_IO, 1'b1, 1'b0, 1'b1, 1'b0);
        run_cycle(16'hD800, 1'b1, 1'b0, 1'b0, CS_ROMD, 1'b1, 1'b0, 1'b1, 1'b0);
        run_cycle(16'hDFFF, 1'b1, 1'b0, 1'b0, CS_ROMD, 1'b1, 1'b0, 1'b1, 1'b0);
        run_cycle(16'hE000, 1'b1, 1'b0, 1'b0, CS_ROMSEL, 1'b1, 1'b0, 1'b1, 1'b0);

        // address/RW change after the sample point is ignored
        run_cycle_glitch(16'hE000, 1'b1, 16'hC000, 1'b0, CS_ROMSEL, 1'b1, 1'b0);

        // halt handshake: request, acknowledge, gated cycles, release
        run_cycle(16'hC000, 1'b1, 1'b1, 1'b0, CS_RAM1, 1'b1, 1'b0, 1'b1, 1'b0);
        run_cycle(16'hC000, 1'b0, 1'b1, 1'b0, CS_RAM1, 1'b0, 1'b1, 1'b0, 1'b0);
        run_cycle(16'hC000, 1'b1, 1'b1, 1'b1, CS_RAM1, 1'b1, 1'b0, 1'b0, 1'b0);
        run_cycle(16'hC000, 1'b1, 1'b1, 1'b1, CS_NONE, 1'b0, 1'b0, 1'b0, 1'b1);
        run_cycle(16'hC000, 1'b0, 1'b0, 1'b1, CS_NONE, 1'b0, 1'b0, 1'b0, 1'b1);
        run_cycle(16'hC000, 1'b1, 1'b0, 1'b0, CS_RAM1, 1'b1, 1'b0, 1'b1, 1'b0);

        // request withdrawn on the same edge BA=BS=1 is seen: no acknowledge
        run_cycle(16'hD400, 1'b1, 1'b1, 1'b0, CS_IO, 1'b1, 1'b0, 1'b1, 1'b0);
        run_cycle(16'hD400, 1'b1, 1'b0, 1'b1, CS_IO, 1'b1, 1'b0, 1'b0, 1'b0);
        run_cycle(16'hD400, 1'b0, 1'b0, 1'b1, CS_IO, 1'b0, 1'b1, 1'b1, 1'b0);
        run_cycle(16'hD400, 1'b1, 1'b0, 1'b0, CS_IO, 1'b1, 1'b0, 1'b1, 1'b0);

        // reset landing on clock 6 of a $C000 write
        bus.SADDRBUS = 16'hC000;
        bus.SRW      = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("write_before_reset", 32'({bus.SWTQEn, bus.SRAM1CSn}), 32'd0);
        @(posedge clk);
        #1;
        check("reset_mid_write", 32'(reset_view()), 32'(RESET_VIEW));
        rst = 1'b0;
        run_cycle(16'hC000, 1'b0, 1'b0, 1'b0, CS_RAM1, 1'b0, 1'b1, 1'b1, 1'b0);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fm7_sub_busctl.md
# fm7_sub_busctl

Sub-system bus controller for the FM-7 display sub-CPU. It generates the sub-6809 E/Q clocks from CLKSYS and latches the sub-CPU address once per bus cycle. It decodes that address into the registered active-low chip selects and read/write strobes consumed by the sub-system memory block and its sibling VRAM and I/O blocks. It also runs the main-CPU halt-request / halt-acknowledge handshake that gates sub-bus activity.

## Interface
Parameters:
- PHASE_LEN, 2: CLKSYS cycles per E/Q quarter-phase. A bus cycle is 4*PHASE_LEN clocks. Legal values are 1 to 15.

Ports:
- CLKSYS  in  1  system clock. All logic is on the rising edge.
- RST  in  1  synchronous, active-high reset.
- SADDRBUS  in  16  sub-CPU address.
- SRW  in  1  sub-CPU R/W: 1 = read, 0 = write.
- SBA  in  1  sub-CPU BA.
- SBS  in  1  sub-CPU BS.
- MHALTREQ  in  1  level-sensitive halt request from the main-side $FD05 latch.
- SE  out  1  sub-CPU E clock.
- SQ  out  1  sub-CPU Q clock.
- SHALTn  out  1  HALT input to the sub-CPU.
- SHALTACK  out  1  sub-CPU is halted and the bus is free (main-side BUSY status).
- SRAM1CSn  out  1  work RAM 1 select, $C000-$C7FF.
- SRAM2CSn  out  1  work RAM 2 select, $C800-$CFFF.
- SSHRCSn  out  1  shared RAM select, $D380-$D3FF.
- SIOCSn  out  1  sub I/O select, $D400-$D7FF.
- SROMDn  out  1  CG ROM select, $D800-$DFFF.
- SROMSELn  out  1  monitor ROM select, $E000-$FFFF.
- SVRAMCSn  out  1  VRAM select, $0000-$BFFF.
- SRDQEn  out  1  read strobe, active low.
- SWTQEn  out  1  write strobe, active low.
- SCYCEND  out  1  one-clock pulse on the last clock of every bus cycle.

## Operation
- **Phase counter.** A sub-counter counts 0 to PHASE_LEN-1. A phase counter p advances 0, 1, 2, 3, 0 each time the sub-counter wraps.
- **Clock outputs per phase.**
  - p0: SE=0, SQ=0.
  - p1: SE=0, SQ=1.
  - p2: SE=1, SQ=1.
  - p3: SE=1, SQ=0.
- **Decode.**
  - SADDRBUS and SRW are registered on the first clock of p1.
  - Exactly one CS is driven low from p1 through the end of p3.
  - All CS are high during p0.
  - $D000-$D37F is unmapped: no CS is asserted and no strobe is asserted.
- **Strobes.** Strobes are asserted only when a CS is active.
  - Read (SRW=1): SRDQEn is low for all of p2 and p3.
  - Write (SRW=0): SWTQEn is low for p3 only.
  - SRDQEn and SWTQEn are never low together.
- **Halt FSM.** The states are RUN, REQ and HALTED. Every transition is evaluated only on the last clock of p3 (the E falling edge).
  - RUN → REQ: when MHALTREQ=1. SHALTn goes low.
  - REQ → HALTED: when SBA=1 and SBS=1. SHALTACK goes to 1.
  - REQ → RUN: when MHALTREQ=0 before the acknowledge. SHALTn returns high.
  - HALTED → RUN: when MHALTREQ=0. SHALTn=1 and SHALTACK=0 take effect together.
- **Bus gating in HALTED.**
  - All CS and strobes are forced high for every cycle that begins in HALTED.
  - SE and SQ keep running.
- **Bus gating in REQ.** CS and strobes operate normally, because the CPU finishes its current instruction.

## Timing
- **Reset values.**
  - Counters are 0, phase is p0, FSM is in RUN.
  - SE=0, SQ=0, SHALTn=1, SHALTACK=0.
  - All CS are 1, SRDQEn=1, SWTQEn=1, SCYCEND=0.
- **Reset mid-cycle.** The next clock after RST shows the reset values. Any in-flight strobe is dropped immediately; no partial write completes.
- **Output registration.** All outputs are registered, with zero combinational paths from inputs to outputs.
- **CS latency.** A CS goes low 1 clock after the address is sampled. With PHASE_LEN=2 this is clock 3 of the cycle, counting from 0. The CS stays low through clock 7.
- **Strobe windows (PHASE_LEN=2).**
  - SRDQEn is low on clocks 4-7.
  - SWTQEn is low on clocks 6-7.
  - SCYCEND is high on clock 7.
- **Address changes mid-cycle.** Changes to SADDRBUS after the p1 sample are ignored until the next p1.
- **Simultaneous halt events.** If MHALTREQ deasserts on the same evaluation edge at which BA=BS=1 is seen in REQ, the FSM goes to RUN and SHALTACK never pulses.
- **Halt acknowledge latency.** SHALTACK rises no earlier than one full bus cycle after SHALTn falls.

## Test plan
- **Reset and free-run:** release RST with PHASE_LEN=2 → SE/SQ follow the pattern 00,00,01,01,11,11,10,10 repeating; all CS and strobes stay high while SADDRBUS=$D000.
- **Monitor ROM read:** SADDRBUS=$E123, SRW=1 → SROMSELn low on clocks 3-7, SRDQEn low on clocks 4-7, all other CS high.
- **Work RAM write:** SADDRBUS=$C800, SRW=0 → SRAM2CSn low on clocks 3-7, SWTQEn low on clocks 6-7 only; a repeat at $C7FF selects SRAM1CSn instead.
- **Boundary decode:** sweep $BFFF, $C000, $D37F, $D380, $D3FF, $D400, $D7FF, $D800, $DFFF, $E000 → VRAM, RAM1, none, SHR, SHR, IO, IO, ROMD, ROMD, ROMSEL respectively.
- **Halt handshake:** MHALTREQ=1 → SHALTn falls at the next E fall; then BA=BS=1 → SHALTACK=1 at the following E fall and no CS is asserted while SADDRBUS=$C000; then MHALTREQ=0 → SHALTn=1 and SHALTACK=0 on the same clock.
- **Reset during write:** assert RST on clock 6 of a $C000 write → SWTQEn=1 and SRAM1CSn=1 on the next clock, FSM is in RUN, phase is p0.
